lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator between the CPU execute stage and the 64x32 word-only synchronous data RAM. The RAM has a 1-cycle registered read and full-word writes only.
- Accepts one CPU request at a time.
- Sequences RAM reads and writes, with read-modify-write for byte/halfword stores.
- Returns extracted, sign/zero-extended load data and an error flag for misaligned or illegal accesses.

Parameters:
ADDR_W, 6, RAM word-address width (depth 2^ADDR_W words)
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  block can accept request (high only in IDLE, low while rst=1)
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result (0 for stores and errors)
resp_err  output  1  misaligned or illegal funct3; qualified by resp_valid
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_W  RAM word address
mem_din  output  32  RAM write data
mem_dout  input  32  RAM read data, valid the cycle after address presented

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- Reset: state=IDLE. resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_din=0. Registered outputs take these values at the reset edge.
- mem_we is gated with !rst, so no RAM write occurs in any cycle where rst=1.
- Accept: handshake occurs on req_valid & req_ready. At that edge, capture we, funct3, addr, wdata.
- Word index: addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- Legality:
  - Loads allow funct3 0,1,2,4,5; stores allow 0,1,2.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - An illegal or misaligned request goes IDLE->RESP with resp_err=1. No RAM access; mem_we never asserted.
- Load: IDLE->RD_ADDR (mem_addr=word, mem_we=0)->RD_DATA (sample mem_dout, extract lane, extend)->RESP.
  - resp_valid is high in the 3rd cycle after the accept edge.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW: IDLE->WR (mem_we=1, mem_din=wdata)->RESP. resp_valid in 2nd cycle after accept.
- SB/SH: IDLE->RD_ADDR->RD_DATA (merge wdata low byte/half into the read word at the lane)->WR (write merged word)->RESP. resp_valid in 4th cycle after accept.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
  - resp_rdata/resp_err are held until the next RESP; they are valid only while resp_valid=1.
- req_ready is combinational: (state==IDLE) & !rst. Back-to-back: the next request can be accepted in the cycle after RESP.
- mem_addr holds the captured word index during RD_ADDR, RD_DATA, and WR. mem_din is meaningful only in WR.
- Reset mid-operation aborts to IDLE with no response. An SB/SH aborted before WR leaves RAM unchanged.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - state enum;
  - helper function for the alignment check.
- One combinational sub-module, lsu_lane_align, does load extraction/extension and store merge. Inputs: word, addr[1:0], funct3, wdata. Outputs: load_data, merged_word.

Test Plan:
- SW 0x12345678 @0x08, then LW @0x08 -> mem_we one cycle at word 2; resp_rdata=0x12345678; LW resp_valid 3 cycles after accept.
- Word 2 = 0x12345678, SB 0xAB @0x09, then LW @0x08 -> exactly one RAM write of 0x1234AB78; LW returns 0x1234AB78.
- Word 3 = 0x00008000: LB @0x0D -> 0xFFFFFF80; LBU @0x0D -> 0x00000080; LH @0x0C -> 0xFFFF8000; LHU @0x0C -> 0x00008000.
- LH @0x05, SW @0x06, LW with funct3=3 -> each gives resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept; mem_we stays 0.
- SH 0xBEEF @0x10 with rst asserted during RD_DATA -> RESP never asserted; a following LW @0x10 returns the original word.
- SW @0x100 (ADDR_W=6) -> writes word 0. Two back-to-back requests with req_valid held high -> the second is accepted the cycle after the first RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_RESP
  } state_t;

  // Stores only know signed widths; loads additionally accept BU/HU.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return !addr_lo[0];
      F3_W:        return (addr_lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// CPU request/response and RAM port bundle for the load/store unit.
// The slave modport is the LSU's view; master is the CPU/RAM side.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word and
// merges sub-word store data into a RAM word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword out of the read word.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend according to the load width code.
  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'd0;
    endcase
  end

  // Each byte lane either keeps the old RAM byte or takes store data.
  // Sub-word store data is LSB-aligned, so a halfword lane picks the low or
  // high byte of wdata[15:0] depending on its position inside the half.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_hit;
    logic [7:0] lane_src;

    assign lane_hit = (funct3 == F3_W)
                   || ((funct3 == F3_H) && (addr_lo[1] == LANE[1]))
                   || ((funct3 == F3_B) && (addr_lo == LANE));
    assign lane_src = (funct3 == F3_W) ? wdata[8*gi +: 8]
                    : (funct3 == F3_H) ? wdata[8*(gi % 2) +: 8]
                    : wdata[7:0];
    assign merged_word[8*gi +: 8] = lane_hit ? lane_src : word[8*gi +: 8];
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one CPU request at a time, sequences the
// single-port word RAM (with read-modify-write for sub-word stores) and
// returns extended load data or an error flag.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.slave  bus
);

  state_t              state_reg, state_next;

  logic                we_reg;
  logic [2:0]          funct3_reg;
  logic [1:0]          addr_lo_reg;
  logic [DATA_W-1:0]   wdata_reg;

  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_din_reg, mem_din_next;
  logic                resp_valid_reg, resp_valid_next;
  logic [DATA_W-1:0]   resp_rdata_reg, resp_rdata_next;
  logic                resp_err_reg, resp_err_next;

  logic                accept;
  logic                req_ok;
  logic [31:0]         load_data;
  logic [31:0]         merged_word;

  assign bus.req_ready = (state_reg == ST_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_ok        = funct3_legal(bus.req_we, bus.req_funct3)
                      && is_aligned(bus.req_funct3, bus.req_addr[1:0]);

  // Lane logic always works on the captured request and the RAM output.
  lsu_lane_align u_lane_align (
    .word        (bus.mem_dout),
    .addr_lo     (addr_lo_reg),
    .funct3      (funct3_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: illegal requests skip the RAM, full-word stores skip the read.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!req_ok)                                   state_next = ST_RESP;
          else if (bus.req_we && bus.req_funct3 == F3_W) state_next = ST_WR;
          else                                           state_next = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: state_next = ST_RD_DATA;
      ST_RD_DATA: state_next = we_reg ? ST_WR : ST_RESP;
      ST_WR:      state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output next-values; all outputs are registered so they line up with state.
  always_comb begin
    mem_we_next     = (state_next == ST_WR);
    mem_addr_next   = accept ? bus.req_addr[ADDR_W+1:2] : mem_addr_reg;
    mem_din_next    = mem_din_reg;
    resp_valid_next = (state_next == ST_RESP);
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;

    if (accept)
      mem_din_next = bus.req_wdata;
    else if (state_reg == ST_RD_DATA)
      mem_din_next = merged_word;

    if (state_next == ST_RESP) begin
      resp_err_next   = (state_reg == ST_IDLE);
      resp_rdata_next = (state_reg == ST_RD_DATA && !we_reg) ? load_data : '0;
    end
  end

  // Request capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg         <= 1'b0;
      funct3_reg     <= 3'd0;
      addr_lo_reg    <= 2'd0;
      wdata_reg      <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg      <= bus.req_we;
        funct3_reg  <= bus.req_funct3;
        addr_lo_reg <= bus.req_addr[1:0];
        wdata_reg   <= bus.req_wdata;
      end
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_din_reg    <= mem_din_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  // Write enable is also blocked combinationally so a reset cycle never writes.
  assign bus.mem_we     = mem_we_reg && !rst;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_din    = mem_din_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 64x32 registered-read RAM model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic clk;
  logic rst;

  lsu_mem_master_if #(.ADDR_W(6)) bus ();

  lsu_mem_master #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, full-word write, with write bookkeeping.
  logic [31:0] ram [64];
  int          wr_count = 0;
  logic [5:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_din;
      wr_count          <= wr_count + 1;
      last_wr_addr      <= bus.mem_addr;
      last_wr_data      <= bus.mem_din;
    end
    bus.mem_dout <= ram[bus.mem_addr];
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request, wait for accept, then count cycles until resp_valid.
  // req_valid is left high so a following call can chain back-to-back.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int waits);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
    $display("[TB] req we=%0d f3=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
             we, f3, addr, wd, rd, err, lat);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, waits, wr0;
  logic        saw_resp;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",      32'(bus.req_ready),  32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_din",    bus.mem_din,         32'd0);
    check("rst_rdata",      bus.resp_rdata,      32'd0);
    check("rst_err",        32'(bus.resp_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SW 0x12345678 @0x08
    wr0 = wr_count;
    do_req(1'b1, F3_W, 32'h08, 32'h12345678, rd, err, lat, waits);
    check("sw_lat",   32'(lat), 32'd2);
    check("sw_err",   32'(err), 32'd0);
    check("sw_rdata", rd,       32'd0);
    @(posedge clk); #1;
    check("sw_pulse_one_cycle", 32'(bus.resp_valid), 32'd0);
    check("sw_nwrites",  32'(wr_count - wr0), 32'd1);
    check("sw_wr_addr",  32'(last_wr_addr),   32'd2);
    check("sw_wr_data",  last_wr_data,        32'h12345678);
    idle();

    // LW @0x08
    do_req(1'b0, F3_W, 32'h08, 32'h0, rd, err, lat, waits);
    check("lw_lat",   32'(lat), 32'd3);
    check("lw_rdata", rd,       32'h12345678);
    check("lw_err",   32'(err), 32'd0);
    idle();

    // SB 0xAB @0x09 (upper wdata bits must be ignored)
    wr0 = wr_count;
    do_req(1'b1, F3_B, 32'h09, 32'hFFFFFFAB, rd, err, lat, waits);
    check("sb_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    check("sb_nwrites", 32'(wr_count - wr0), 32'd1);
    check("sb_wr_data", last_wr_data,        32'h1234AB78);
    idle();
    do_req(1'b0, F3_W, 32'h08, 32'h0, rd, err, lat, waits);
    check("sb_readback", rd, 32'h1234AB78);
    idle();

    // Word 3 = 0x00008000, sub-word loads with extension
    do_req(1'b1, F3_W, 32'h0C, 32'h00008000, rd, err, lat, waits);
    idle();
    do_req(1'b0, F3_B, 32'h0D, 32'h0, rd, err, lat, waits);
    check("lb_0d", rd, 32'hFFFFFF80);
    idle();
    do_req(1'b0, F3_BU, 32'h0D, 32'h0, rd, err, lat, waits);
    check("lbu_0d", rd, 32'h00000080);
    idle();
    do_req(1'b0, F3_H, 32'h0C, 32'h0, rd, err, lat, waits);
    check("lh_0c", rd, 32'hFFFF8000);
    idle();
    do_req(1'b0, F3_HU, 32'h0C, 32'h0, rd, err, lat, waits);
    check("lhu_0c", rd, 32'h00008000);
    idle();

    // SH 0xBEEF into the upper half of word 3
    do_req(1'b1, F3_H, 32'h0E, 32'h1234BEEF, rd, err, lat, waits);
    check("sh_lat", 32'(lat), 32'd4);
    idle();
    do_req(1'b0, F3_W, 32'h0C, 32'h0, rd, err, lat, waits);
    check("sh_readback", rd, 32'hBEEF8000);
    idle();
    do_req(1'b0, F3_H, 32'h0E, 32'h0, rd, err, lat, waits);
    check("lh_0e", rd, 32'hFFFFBEEF);
    idle();
    do_req(1'b0, F3_B, 32'h0F, 32'h0, rd, err, lat, waits);
    check("lb_0f", rd, 32'hFFFFFFBE);
    idle();

    // Illegal / misaligned requests
    wr0 = wr_count;
    do_req(1'b0, F3_H, 32'h05, 32'h0, rd, err, lat, waits);
    check("lh_mis_err",   32'(err), 32'd1);
    check("lh_mis_rdata", rd,       32'd0);
    check("lh_mis_lat",   32'(lat), 32'd1);
    idle();
    do_req(1'b1, F3_W, 32'h06, 32'hDEADBEEF, rd, err, lat, waits);
    check("sw_mis_err", 32'(err), 32'd1);
    check("sw_mis_lat", 32'(lat), 32'd1);
    idle();
    do_req(1'b0, 3'd3, 32'h08, 32'h0, rd, err, lat, waits);
    check("f3_ill_err",   32'(err), 32'd1);
    check("f3_ill_rdata", rd,       32'd0);
    idle();
    do_req(1'b1, F3_BU, 32'h08, 32'h0, rd, err, lat, waits);
    check("sbu_ill_err", 32'(err), 32'd1);
    idle();
    check("err_no_writes", 32'(wr_count - wr0), 32'd0);

    // Reset during RD_DATA of an SH must not write or respond
    do_req(1'b1, F3_W, 32'h10, 32'hCAFEF00D, rd, err, lat, waits);
    idle();
    wr0 = wr_count;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0000BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_addr", 32'(bus.mem_addr), 32'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
    check("abort_we_in_rst",    32'(bus.mem_we),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      saw_resp = saw_resp | bus.resp_valid;
    end
    check("abort_no_resp",  32'(saw_resp),         32'd0);
    check("abort_no_write", 32'(wr_count - wr0),   32'd0);
    $display("[TB] SH @0x10 aborted by reset in RD_DATA");
    do_req(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat, waits);
    check("abort_readback", rd, 32'hCAFEF00D);
    idle();

    // Address wrap: 0x100 maps to word 0
    do_req(1'b1, F3_W, 32'h100, 32'h0BADBEEF, rd, err, lat, waits);
    @(posedge clk); #1;
    check("wrap_wr_addr", 32'(last_wr_addr), 32'd0);
    idle();
    do_req(1'b0, F3_W, 32'h00, 32'h0, rd, err, lat, waits);
    check("wrap_readback", rd, 32'h0BADBEEF);
    idle();

    // Back-to-back with req_valid held high
    do_req(1'b1, F3_W, 32'h14, 32'h55AA55AA, rd, err, lat, waits);
    check("b2b_first_lat", 32'(lat), 32'd2);
    do_req(1'b0, F3_W, 32'h14, 32'h0, rd, err, lat, waits);
    check("b2b_accept_gap", 32'(waits), 32'd1);
    check("b2b_second_lat", 32'(lat),   32'd3);
    check("b2b_rdata",      rd,         32'h55AA55AA);
    idle();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
